// File: rtl/axis_mux_pkg.sv
// Shared types and helpers for the round-robin AXI4-Stream packet mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: arbitration FSM state enum, index-width helper, stats counter width.
package axis_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int STATS_CNT_W = 32;

  // Width of an index into n ports; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register FIFO that decouples the master ready from the slave side.
// Latency: a push at edge k is visible on head after edge k.
// Backpressure: push is ignored when full; count drives the upstream ready.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset (clears entries and count)
//   push, din  - write strobe and beat to store
//   pop        - read strobe (ignored when empty)
//   head       - oldest stored beat
//   count      - occupancy, 0..2
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop  && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_rr_packet_mux.sv
// N-input AXI4-Stream packet mux, round-robin and packet-atomic, onto one master.
// Latency: request at t -> grant/ready at t+1; beat accepted at k appears on m_* at k+1.
// Backpressure: 2-entry output skid; s_tready derives from registered occupancy only.
// Ports:
//   clk, rst_n                        - clock, synchronous active-low reset
//   s_req_supress                     - per-port mask applied at arbitration only
//   s_tdata_i/tuser_i/tkeep_i/tlast_i - flattened slave beats, port i at [i*W +: W]
//   s_tvalid_i, s_tready_o            - per-port slave handshake
//   m_tdata_o/tuser_o/tkeep_o/tlast_o - master beat (head of skid stage)
//   m_tvalid_o, m_tready_i            - master handshake
//   pkt_cnt_o                         - per-port packet counters (AXIS_MUX_STATS_EN only)
//   grant_o                           - one-hot owner of the output, zero when idle
// Build option: define AXIS_MUX_STATS_EN to add pkt_cnt_o and its counters.
module axis_rr_packet_mux
  import axis_mux_pkg::*;
#(
  parameter int NUM_S   = 4,
  parameter int TDATA_L = 512,
  parameter int TUSER_L = 81,
  parameter int TKEEP_L = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_S-1:0]         s_req_supress,
  input  logic [NUM_S*TDATA_L-1:0] s_tdata_i,
  input  logic [NUM_S*TUSER_L-1:0] s_tuser_i,
  input  logic [NUM_S*TKEEP_L-1:0] s_tkeep_i,
  input  logic [NUM_S-1:0]         s_tlast_i,
  input  logic [NUM_S-1:0]         s_tvalid_i,
  output logic [NUM_S-1:0]         s_tready_o,
  output logic [TDATA_L-1:0]       m_tdata_o,
  output logic [TUSER_L-1:0]       m_tuser_o,
  output logic [TKEEP_L-1:0]       m_tkeep_o,
  output logic                     m_tlast_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
`ifdef AXIS_MUX_STATS_EN
  output logic [NUM_S*STATS_CNT_W-1:0] pkt_cnt_o,
`endif
  output logic [NUM_S-1:0]         grant_o
);

  localparam int IW     = idx_w(NUM_S);
  localparam int BEAT_W = TDATA_L + TUSER_L + TKEEP_L + 1;

  state_t           state_q, state_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    ptr_next;
  logic [NUM_S-1:0] req;
  logic [NUM_S-1:0] req_rearb;
  logic [1:0]       skid_cnt;
  logic             room;
  logic             accept;
  logic             last_acc;
  logic [BEAT_W-1:0] beat_in;
  logic [BEAT_W-1:0] beat_out;

  // Cyclic first-set-bit search starting at ptr: look at bits >= ptr first,
  // fall back to the whole vector when none of those are set.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_S-1:0] r,
                                            input logic [IW-1:0]    ptr);
    logic [NUM_S-1:0] hi;
    logic [NUM_S-1:0] src;
    logic [IW-1:0]    win;
    hi  = r & ~((NUM_S'(1) << ptr) - NUM_S'(1));
    src = (|hi) ? hi : r;
    win = '0;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if (src[i]) win = IW'(i);
    end
    return win;
  endfunction

  assign req       = s_tvalid_i & ~s_req_supress;
  assign req_rearb = req & ~(NUM_S'(1) << gidx_q);
  assign ptr_next  = (gidx_q == IW'(NUM_S - 1)) ? '0 : gidx_q + 1'b1;

  assign room       = (skid_cnt != 2'd2);
  assign grant_o    = (state_q == LOCK) ? (NUM_S'(1) << gidx_q) : '0;
  assign s_tready_o = room ? grant_o : '0;

  assign accept   = (state_q == LOCK) && room && s_tvalid_i[gidx_q];
  assign last_acc = accept && s_tlast_i[gidx_q];

  assign beat_in = {s_tdata_i[gidx_q*TDATA_L +: TDATA_L],
                    s_tuser_i[gidx_q*TUSER_L +: TUSER_L],
                    s_tkeep_i[gidx_q*TKEEP_L +: TKEEP_L],
                    s_tlast_i[gidx_q]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = LOCK;
          gidx_d  = rr_pick(req, ptr_q);
        end
      end
      LOCK: begin
        // Re-arbitrate in the tlast cycle so back-to-back packets from
        // different ports leave no bubble; the finishing port sits out.
        if (last_acc) begin
          ptr_d = ptr_next;
          if (|req_rearb) begin
            gidx_d = rr_pick(req_rearb, ptr_next);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  axis_skid_buf #(
    .W (BEAT_W)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (beat_in),
    .pop   (m_tready_i),
    .head  (beat_out),
    .count (skid_cnt)
  );

  assign {m_tdata_o, m_tuser_o, m_tkeep_o, m_tlast_o} = beat_out;
  assign m_tvalid_o = (skid_cnt != 2'd0);

`ifdef AXIS_MUX_STATS_EN
  logic [NUM_S-1:0][STATS_CNT_W-1:0] pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else if (last_acc) begin
      pkt_cnt_q[gidx_q] <= pkt_cnt_q[gidx_q] + 1'b1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_rr_packet_mux.sv
// Randomized bench for axis_rr_packet_mux with a queue-based reference model.
// Directed phases cover round-robin order, atomicity, suppress, stall, reset.
// Define AXIS_MUX_STATS_EN to also exercise the per-port packet counters.
`timescale 1ns/1ps
module tb_axis_rr_packet_mux;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int UW = 8;
  localparam int KW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    sup;
  logic [N*DW-1:0] s_tdata_i;
  logic [N*UW-1:0] s_tuser_i;
  logic [N*KW-1:0] s_tkeep_i;
  logic [N-1:0]    s_tlast_i;
  logic [N-1:0]    s_tvalid_i;
  logic [N-1:0]    s_tready_o;
  logic [DW-1:0]   m_tdata_o;
  logic [UW-1:0]   m_tuser_o;
  logic [KW-1:0]   m_tkeep_o;
  logic            m_tlast_o;
  logic            m_tvalid_o;
  logic            m_tready_i;
  logic [N-1:0]    grant_o;
`ifdef AXIS_MUX_STATS_EN
  logic [N*32-1:0] pkt_cnt_o;
`endif

  axis_rr_packet_mux #(
    .NUM_S (N), .TDATA_L (DW), .TUSER_L (UW), .TKEEP_L (KW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_req_supress (sup),
    .s_tdata_i     (s_tdata_i),
    .s_tuser_i     (s_tuser_i),
    .s_tkeep_i     (s_tkeep_i),
    .s_tlast_i     (s_tlast_i),
    .s_tvalid_i    (s_tvalid_i),
    .s_tready_o    (s_tready_o),
    .m_tdata_o     (m_tdata_o),
    .m_tuser_o     (m_tuser_o),
    .m_tkeep_o     (m_tkeep_o),
    .m_tlast_o     (m_tlast_o),
    .m_tvalid_o    (m_tvalid_o),
    .m_tready_i    (m_tready_i),
`ifdef AXIS_MUX_STATS_EN
    .pkt_cnt_o     (pkt_cnt_o),
`endif
    .grant_o       (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  beat_t sq [N][$];   // beats each producer still has to send
  beat_t sb [N][$];   // accepted beats awaiting the master, per port
  beat_t mq [$];      // model of the output buffer contents
  logic  mlock = 1'b0;
  int    mg = 0;
  int    mptr = 0;
  int    mstats [N];
  logic [N-1:0] hs = '0;
  logic [N-1:0] vld_r = '0;
  int    valid_pct = 100;
  int    rdy_pct = 100;
  int    pkt_id = 0;
  logic [DW-1:0] obs_d [$];
  int    obs_cyc [$];
  logic  in_pkt = 1'b0;
  int    cur_p = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit coin(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // Winner = requesting port with the smallest cyclic distance from ptr.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  // Reference model: evaluated between edges, predicts the state after the next edge.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic [N-1:0] r;
    beat_t b;
    beat_t ob;
    logic push;
    logic pop;
    int p;
    int avail;
    cyc++;
    if (!rst_n) begin
      mlock = 1'b0; mg = 0; mptr = 0; mq.delete(); hs = '0; in_pkt = 1'b0;
      for (int i = 0; i < N; i++) begin
        sb[i].delete();
        mstats[i] = 0;
      end
    end else begin
      eg = mlock ? (N'(1) << mg) : '0;
      er = (mlock && mq.size() < 2) ? eg : '0;
      chk("grant", grant_o, eg);
      chk("s_tready", s_tready_o, er);
      chk("m_tvalid", m_tvalid_o, mq.size() != 0);
      if (mq.size() != 0) chk("m_beat", {m_tdata_o, m_tuser_o, m_tkeep_o, m_tlast_o}, mq[0]);

      push = mlock && (mq.size() < 2) && s_tvalid_i[mg];
      pop  = (mq.size() != 0) && m_tready_i;
      hs   = push ? eg : '0;

      if (pop) begin
        ob = {m_tdata_o, m_tuser_o, m_tkeep_o, m_tlast_o};
        void'(mq.pop_front());
        p = int'(ob.d[DW-1 -: 8]);
        avail = (p < N) ? sb[p].size() : 0;
        chk("sb_avail", avail != 0, 1'b1);
        if (avail != 0) begin
          chk("sb_beat", ob, sb[p].pop_front());
          if (in_pkt) chk("interleave", p, cur_p);
          cur_p  = p;
          in_pkt = !ob.l;
          obs_d.push_back(ob.d);
          obs_cyc.push_back(cyc);
        end
      end

      b = '0;
      if (push) begin
        b = {s_tdata_i[mg*DW +: DW], s_tuser_i[mg*UW +: UW],
             s_tkeep_i[mg*KW +: KW], s_tlast_i[mg]};
        mq.push_back(b);
        sb[mg].push_back(b);
        if (b.l) mstats[mg]++;
      end

      r = s_tvalid_i & ~sup;
      if (!mlock) begin
        if (r != 0) begin
          mg    = pick(r, mptr);
          mlock = 1'b1;
        end
      end else if (push && b.l) begin
        mptr  = (mg + 1) % N;
        r[mg] = 1'b0;
        if (r != 0) mg = pick(r, mptr);
        else mlock = 1'b0;
      end
    end
  end

  task automatic drive_cycle();
    beat_t f;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        void'(sq[i].pop_front());
        vld_r[i] = 1'b0;
      end
      f = '0;
      if (sq[i].size() != 0) begin
        f = sq[i][0];
        if (!vld_r[i] && coin(valid_pct)) vld_r[i] = 1'b1;
      end else begin
        vld_r[i] = 1'b0;
      end
      s_tdata_i[i*DW +: DW] = f.d;
      s_tuser_i[i*UW +: UW] = f.u;
      s_tkeep_i[i*KW +: KW] = f.k;
      s_tlast_i[i]          = f.l;
    end
    s_tvalid_i = vld_r;
    m_tready_i = coin(rdy_pct);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_cycle();
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    pkt_id++;
    for (int j = 0; j < len; j++) begin
      b.d = {8'(p), 12'(pkt_id), 12'(j)};
      b.u = UW'($urandom);
      b.k = KW'($urandom);
      b.l = (j == len - 1);
      sq[p].push_back(b);
    end
  endtask

  task automatic drain(input string tag);
    int t;
    bit busy;
    t = 0;
    do begin
      step();
      t++;
      busy = (mq.size() != 0) || (vld_r != 0);
      for (int i = 0; i < N; i++) if (sq[i].size() != 0) busy = 1'b1;
    end while (busy && t < 3000);
    chk(tag, busy, 1'b0);
  endtask

  task automatic wait_left(input int p, input int left);
    int t;
    t = 0;
    while (sq[p].size() > left && t < 100) begin
      step();
      t++;
    end
    chk("wait_left", sq[p].size(), left);
  endtask

  initial begin
    int rdy1;
    int left;
    rst_n = 1'b0; sup = '0; m_tready_i = 1'b1;
    s_tdata_i = '0; s_tuser_i = '0; s_tkeep_i = '0; s_tlast_i = '0; s_tvalid_i = '0;
    for (int i = 0; i < N; i++) mstats[i] = 0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_m_tvalid", m_tvalid_o, 1'b0);
    chk("rst_m_tlast", m_tlast_o, 1'b0);
    chk("rst_m_tdata", m_tdata_o, '0);
    chk("rst_m_tuser", m_tuser_o, '0);
    chk("rst_m_tkeep", m_tkeep_o, '0);
    chk("rst_s_tready", s_tready_o, '0);
    chk("rst_grant", grant_o, '0);

    // All ports, single-beat packets at once: strict 0,1,2,3 with no gap.
    while (cyc < 30) step();
    obs_d.delete(); obs_cyc.delete();
    for (int i = 0; i < N; i++) add_pkt(i, 1);
    drain("rr_drain");
    chk("rr_count", obs_d.size(), 4);
    if (obs_d.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_order", obs_d[i][DW-1 -: 8], i);
      for (int i = 1; i < 4; i++) chk("rr_no_bubble", obs_cyc[i] - obs_cyc[i-1], 1);
    end

    // Port2 requests during port1's 3-beat packet: no interleave.
    obs_d.delete();
    add_pkt(1, 3);
    wait_left(1, 2);
    add_pkt(2, 1);
    drain("atomic_drain");
    chk("atomic_count", obs_d.size(), 4);
    if (obs_d.size() >= 4) begin
      for (int i = 0; i < 3; i++) begin
        chk("atomic_port", obs_d[i][DW-1 -: 8], 1);
        chk("atomic_beat", obs_d[i][11:0], i);
      end
      chk("atomic_next", obs_d[3][DW-1 -: 8], 2);
    end

    // Suppressed port1 waits while port3 is served.
    sup = 4'b0010;
    add_pkt(1, 2);
    add_pkt(3, 2);
    rdy1 = 0;
    repeat (20) begin
      step();
      if (s_tready_o[1]) rdy1++;
    end
    chk("sup_rdy1_cycles", rdy1, 0);
    chk("sup_port1_waiting", sq[1].size(), 2);
    chk("sup_port3_done", sq[3].size(), 0);
    sup = '0;
    drain("sup_release");
    // Suppress raised mid-packet does not abort the packet.
    add_pkt(0, 4);
    wait_left(0, 3);
    sup = 4'b0001;
    drain("sup_mid_pkt");
    sup = '0;

    // Master stall during a 5-beat packet.
    add_pkt(2, 5);
    wait_left(2, 4);
    rdy_pct = 0;
    m_tready_i = 1'b0;
    repeat (10) step();
    chk("stall_tready", s_tready_o[2], 1'b0);
    chk("stall_accepted", sq[2].size(), 3);
    chk("stall_mvalid", m_tvalid_o, 1'b1);
    rdy_pct = 100;
    drain("stall_release");

    // Reset after beat 2 of a 4-beat packet; pointer must return to 0.
    add_pkt(1, 4);
    wait_left(1, 2);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) sq[i].delete();
    vld_r = '0;
    s_tvalid_i = '0;
    step();
    rst_n = 1'b1;
    chk("rst2_m_tvalid", m_tvalid_o, 1'b0);
    chk("rst2_grant", grant_o, '0);
    chk("rst2_s_tready", s_tready_o, '0);
    obs_d.delete();
    add_pkt(3, 2);
    add_pkt(0, 2);
    drain("rst2_fresh");
    chk("rst2_count", obs_d.size(), 4);
    if (obs_d.size() >= 4) begin
      chk("rst2_first_port", obs_d[0][DW-1 -: 8], 0);
      chk("rst2_first_beat", obs_d[0][11:0], 0);
    end

`ifdef AXIS_MUX_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) add_pkt(2, 1 + int'($urandom_range(3)));
    add_pkt(0, 2);
    drain("stats_drain");
    chk("stats_p0", pkt_cnt_o[0 +: 32], 1);
    chk("stats_p1", pkt_cnt_o[32 +: 32], 0);
    chk("stats_p2", pkt_cnt_o[64 +: 32], 3);
    chk("stats_p3", pkt_cnt_o[96 +: 32], 0);
`endif

    // Random traffic, valid gaps, master backpressure and suppress changes.
    valid_pct = 70;
    rdy_pct   = 70;
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        if (coin(4) && sq[i].size() < 24) add_pkt(i, 1 + int'($urandom_range(5)));
      end
      if (coin(3)) sup = N'($urandom);
      step();
    end
    sup = '0;
    rdy_pct = 100;
    drain("random_drain");

    left = 0;
    for (int i = 0; i < N; i++) left += sb[i].size();
    chk("sb_leftover", left, 0);
`ifdef AXIS_MUX_STATS_EN
    for (int i = 0; i < N; i++) chk("stats_final", pkt_cnt_o[i*32 +: 32], mstats[i]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_rr_packet_mux.md
# axis_rr_packet_mux

N-input AXI4-Stream packet multiplexer with round-robin, packet-atomic arbitration onto one master port. It generalises the two-port custom switch to NUM_S slave ports with a per-port request-suppress mask and a registered 2-entry output skid stage, so that no combinational path runs from m_tready to any s_tready. It sits between the per-lane stream producers and the single shared egress stream.

## Interface
Parameters:
- NUM_S, 4: number of slave ports, 2..16.
- TDATA_L, 512: tdata width.
- TUSER_L, 81: tuser width.
- TKEEP_L, 16: tkeep width.

Ports (slave buses are flattened, port i occupies slice [i*W +: W]):
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_req_supress  in  NUM_S  1 masks port i from winning arbitration.
- s_tdata_i  in  NUM_S*TDATA_L  slave data.
- s_tuser_i  in  NUM_S*TUSER_L  slave user.
- s_tkeep_i  in  NUM_S*TKEEP_L  slave keep.
- s_tlast_i  in  NUM_S  slave last.
- s_tvalid_i  in  NUM_S  slave valid.
- s_tready_o  out  NUM_S  slave ready.
- m_tdata_o / m_tuser_o / m_tkeep_o / m_tlast_o  out  TDATA_L / TUSER_L / TKEEP_L / 1  master beat.
- m_tvalid_o  out  1  master valid.
- m_tready_i  in  1  master ready.
- grant_o  out  NUM_S  one-hot current grant (all-zero when idle).

## Operation
- FSM with two states. IDLE: no grant. LOCK: one port granted until its tlast beat is accepted.
- Request vector: req = s_tvalid_i & ~s_req_supress.
- In IDLE with req != 0, the first set bit of req at or after rr_ptr (cyclic) wins. The grant is registered, and the FSM moves to LOCK on the next cycle.
- In LOCK, s_tready_o[g] = (skid count < 2); all other s_tready_o bits are 0. Every accepted beat (tvalid && tready) is pushed into the skid stage unchanged, including tkeep.
- On acceptance of the tlast beat of port g:
  - rr_ptr becomes g+1, wrapping at NUM_S.
  - Arbitration runs in the same cycle over req with bit g cleared.
  - If a winner exists, it is granted on the next cycle with no idle bubble. Otherwise the FSM returns to IDLE.
- Suppress is sampled only at arbitration. Asserting it mid-packet does not abort the packet in progress.
- The granted port may drop tvalid mid-packet. The grant is held indefinitely until tlast.
- Skid stage: a 2-entry FIFO. Pushes and pops may occur in the same cycle when not full. The m_* outputs are driven from the head entry, and m_tvalid_o = (count != 0).
- Beat order on the master equals acceptance order. Packets are never interleaved.
- Reset, including mid-packet:
  - FSM goes to IDLE and rr_ptr to 0.
  - Skid count goes to 0, which drops m_tvalid_o to 0.
  - s_tready_o and grant_o go to 0.
  - A partial packet is discarded.

## Timing
- Reset values: m_tvalid_o=0, m_tlast_o=0, m_tdata/tuser/tkeep=0, s_tready_o=0, grant_o=0.
- Request at cycle t in IDLE: grant_o and s_tready_o assert at t+1, and the first beat is accepted at t+1 if tvalid is held.
- Acceptance at cycle k: the beat is visible on m_* at k+1.
- Throughput: 1 beat/cycle while m_tready_i=1. When m_tready_i is low, the skid stage fills in 2 beats and s_tready_o falls on the following cycle.
- s_tready_o depends only on registered state.

## Configuration
- AXIS_MUX_STATS_EN defined:
  - Adds output pkt_cnt_o, NUM_S*32 bits.
  - Per-port 32-bit wrapping counters increment on each accepted tlast beat from that port.
  - Counters are cleared by reset.
- AXIS_MUX_STATS_EN undefined: the port and counters are absent. All other behaviour is identical.

## Structure
- Package axis_mux_pkg contains:
  - State enum {IDLE, LOCK}.
  - Index-width function (clog2 of NUM_S, minimum 1).
  - Stats counter width constant (32).
- Sub-module axis_skid_buf (2-entry register FIFO carrying {tdata, tuser, tkeep, tlast}) is instantiated once at the output.
- Round-robin pick is a function inside the top module.

## Test plan
- NUM_S=4: single-beat packets on all ports simultaneously at cycle 30 with m_tready=1. Required: master order 0,1,2,3; each grant lasts 1 cycle with no idle cycle between grants.
- Port1 sends a 3-beat packet while port2 requests at the second beat. Required: beats A1,A2,A3 are contiguous, then port2's beat follows with no interleave.
- s_req_supress=4'b0010, ports 1 and 3 valid. Required: port3 is served and port1 gets no s_tready until suppress clears. Asserting suppress on port0 mid-packet still completes port0's packet.
- m_tready_i held low for 10 cycles during a 5-beat packet. Required: s_tready drops after 2 buffered beats, no beat is lost or duplicated, and order is preserved on release.
- rst_n pulled low for 1 cycle after beat 2 of a 4-beat packet. Required: next cycle m_tvalid=0, grant_o=0, rr_ptr=0, and a fresh packet from port0 is then forwarded cleanly.
- With AXIS_MUX_STATS_EN defined: 3 packets from port2 and 1 from port0. Required: pkt_cnt for port2 = 3, port0 = 1, others 0.
